// File: rtl/countdown_timer_pkg.sv
// Shared constants and types for the M:SS BCD countdown timer.
package countdown_timer_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t SEC_ONES_MAX = 4'd9;
  localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
  localparam bcd_digit_t MINS_MAX     = 4'd9;

  // Minutes load values above 9 are not BCD; saturate them to 9.
  function automatic bcd_digit_t clamp_mins(input logic [3:0] v);
    return (v > MINS_MAX) ? MINS_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with synchronous load and wrap-to-MAX borrow.
module bcd_down_digit
  import countdown_timer_pkg::*;
#(
  parameter bcd_digit_t MAX = 4'd9
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic       load,
  input  bcd_digit_t load_val,
  input  logic       dec,
  output bcd_digit_t q,
  output logic       borrow
);

  bcd_digit_t q_q;
  bcd_digit_t q_d;

  // Next digit value: load wins over decrement; 0 wraps to MAX on decrement.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (dec) begin
      q_d = (q_q == '0) ? MAX : q_q - 4'd1;
    end
  end

  // Digit register, cleared asynchronously.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign borrow = dec && (q_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// Three-digit M:SS BCD countdown timer; stops and holds at 0:00.
module countdown_timer
  import countdown_timer_pkg::*;
(
  input  logic       clock,
  input  logic       clrn,
  input  logic [3:0] data,
  input  logic       loadn,
  input  logic       enable,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] mins,
  output logic       zero
);

  logic       load;
  logic       ones_dec;
  logic       ones_borrow;
  logic       tens_borrow;
  logic       mins_borrow;
  bcd_digit_t mins_load_val;

  // Load and count gating; the zero term keeps 0:00 from wrapping to 9:59.
  always_comb begin
    load          = !loadn;
    ones_dec      = loadn && enable && !zero;
    mins_load_val = clamp_mins(data);
  end

  bcd_down_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clock    (clock),
    .clrn     (clrn),
    .load     (load),
    .load_val ('0),
    .dec      (ones_dec),
    .q        (sec_ones),
    .borrow   (ones_borrow)
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clock    (clock),
    .clrn     (clrn),
    .load     (load),
    .load_val ('0),
    .dec      (ones_borrow),
    .q        (sec_tens),
    .borrow   (tens_borrow)
  );

  bcd_down_digit #(.MAX(MINS_MAX)) u_mins (
    .clock    (clock),
    .clrn     (clrn),
    .load     (load),
    .load_val (mins_load_val),
    .dec      (tens_borrow),
    .q        (mins),
    .borrow   (mins_borrow)
  );

  // Combinational terminal-count decode of the registered digits.
  always_comb begin
    zero = (mins == '0) && (sec_tens == '0) && (sec_ones == '0);
  end

  // The minutes borrow can only fire at 0:00, which the gating above blocks.
  logic unused_borrow;
  assign unused_borrow = mins_borrow;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  logic       clock = 1'b0;
  logic       clrn;
  logic [3:0] data;
  logic       loadn;
  logic       enable;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] mins;
  logic       zero;

  int unsigned tests = 0;
  int unsigned fails = 0;

  countdown_timer dut (
    .clock    (clock),
    .clrn     (clrn),
    .data     (data),
    .loadn    (loadn),
    .enable   (enable),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .mins     (mins),
    .zero     (zero)
  );

  always #5 clock = ~clock;

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // exp packs {zero, mins, sec_tens, sec_ones}
  task automatic check(input string tag, input logic [12:0] exp);
    logic [12:0] obs;
    obs = {zero, mins, sec_tens, sec_ones};
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed zero/M/T/O=%h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    clrn   = 1'b0;
    loadn  = 1'b1;
    enable = 1'b0;
    data   = 4'd0;
    #3;
    check("reset_async", 13'h1000);
    tick(2);
    check("reset_held", 13'h1000);
    clrn   = 1'b1;
    enable = 1'b1;
    tick(3);
    check("post_reset_no_load", 13'h1000);

    // Clamp: 12 loads as 9:00
    enable = 1'b0;
    data   = 4'd12;
    loadn  = 1'b0;
    tick(1);
    loadn  = 1'b1;
    check("load_clamp_12", 13'h0900);

    // Load 4 with enable high: load wins
    data   = 4'd4;
    enable = 1'b1;
    loadn  = 1'b0;
    tick(1);
    loadn  = 1'b1;
    enable = 1'b0;
    check("load_4", 13'h0400);

    enable = 1'b1;
    tick(1);
    check("count_1", 13'h0359);
    tick(1);
    check("count_2", 13'h0358);
    tick(8);
    check("count_10", 13'h0350);
    tick(50);
    check("count_60", 13'h0300);
    tick(179);
    check("count_239", 13'h0001);
    tick(1);
    check("count_240_zero", 13'h1000);
    tick(5);
    check("terminal_hold", 13'h1000);

    // Load 1, count to 0:45, then gate enable
    data  = 4'd1;
    loadn = 1'b0;
    tick(1);
    loadn = 1'b1;
    check("load_1", 13'h0100);
    tick(15);
    check("count_to_045", 13'h0045);
    enable = 1'b0;
    tick(3);
    check("enable_off_hold", 13'h0045);
    enable = 1'b1;
    tick(1);
    check("enable_resume", 13'h0044);

    // Load priority over enable
    data  = 4'd2;
    loadn = 1'b0;
    tick(1);
    loadn = 1'b1;
    enable = 1'b0;
    check("load_over_enable", 13'h0200);

    // Reset mid-count at 2:17
    data  = 4'd3;
    loadn = 1'b0;
    tick(1);
    loadn  = 1'b1;
    enable = 1'b1;
    check("load_3", 13'h0300);
    tick(43);
    check("count_to_217", 13'h0217);
    #2;
    clrn = 1'b0;
    #1;
    check("midcount_reset_async", 13'h1000);
    #1;
    clrn = 1'b1;
    tick(3);
    check("no_resume_after_reset", 13'h1000);

    // Clamp of 15
    data  = 4'd15;
    loadn = 1'b0;
    tick(1);
    loadn = 1'b1;
    enable = 1'b0;
    check("load_clamp_15", 13'h0900);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
